// File: rtl/psram_pkg.sv
// ----------------------------------------------------------------------------
// psram_pkg
// Shared definitions for the PSRAM link: the QPI/SPI command opcodes the
// responder understands and the responder's frame-level state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package psram_pkg;

    // Command opcodes seen on the link.
    typedef enum logic [7:0] {
        CMD_ENTER_QPI  = 8'h35,  // SPI only: switch to QPI after the frame
        CMD_EXIT_QPI   = 8'hF5,  // QPI only: back to SPI after the frame
        CMD_RST_EN     = 8'h66,  // arms a reset
        CMD_RST        = 8'h99,  // reset, only when armed by the previous frame
        CMD_QUAD_WRITE = 8'h38,
        CMD_QUAD_READ  = 8'hEB
    } qpi_cmd_e;

    // Responder frame state.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_WR_DATA = 3'd5,
        ST_IGNORE  = 3'd6
    } resp_state_e;

    // Address nibbles sent in every read/write frame (24-bit address).
    localparam int ADDR_NIBBLES = 6;

endpackage

// File: rtl/psram_byte_ram.sv
// ----------------------------------------------------------------------------
// psram_byte_ram
// Single-port byte array backing the responder. Writes are synchronous; the
// read port is registered (data for `addr` appears one clk later). No reset,
// so contents survive a responder reset.
// Ports:
//   clk    in   system clock
//   we     in   write enable (writes wdata to addr on this posedge)
//   addr   in   byte address
//   wdata  in   byte to write
//   rdata  out  byte at addr, registered
// ----------------------------------------------------------------------------
module psram_byte_ram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [2**ADDR_WIDTH];

    // Read-first: a read in the same cycle as a write returns the old byte.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/psram_qpi_responder.sv
// ----------------------------------------------------------------------------
// psram_qpi_responder
// Device end of a 4-bit PSRAM link. Oversamples chip select, serial clock and
// data on the system clock, decodes SPI/QPI frames (enter/exit QPI, reset
// enable + reset, quad write 0x38, quad fast read 0xEB) and serves them from
// an internal byte array.
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous reset, active low
//   i_psram_cs    in   chip select, active low
//   i_psram_sclk  in   serial clock from the controller
//   i_sio[3:0]    in   data lines at the pins
//   o_sio[3:0]    out  read data toward the controller
//   o_sio_oe      out  1 = o_sio drives the pins
//   o_qpi_mode    out  1 = device is in QPI mode
// Handshake: there is none; the controller owns sclk. Data is captured on
// detected sclk rises and read data is launched on detected sclk falls, so
// the controller samples on its next rise. sclk must stay at most clk/4.
// ----------------------------------------------------------------------------
module psram_qpi_responder
    import psram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,   // must be 5..24
    parameter int READ_WAIT  = 6     // must be 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_psram_cs,
    input  logic       i_psram_sclk,
    input  logic [3:0] i_sio,
    output logic [3:0] o_sio,
    output logic       o_sio_oe,
    output logic       o_qpi_mode
);

    localparam logic [7:0] WAIT_LAST = 8'(READ_WAIT - 1);

    // ---------------- input registers and edge detect ----------------
    logic       cs_q, cs_d, sclk_q, sclk_d;
    logic [3:0] sio_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q   <= 1'b1;
            cs_d   <= 1'b1;
            sclk_q <= 1'b0;
            sclk_d <= 1'b0;
            sio_q  <= 4'h0;
        end else begin
            cs_q   <= i_psram_cs;
            cs_d   <= cs_q;
            sclk_q <= i_psram_sclk;
            sclk_d <= sclk_q;
            sio_q  <= i_sio;
        end
    end

    logic cs_rise, cs_fall, sclk_rise, sclk_fall;
    assign cs_rise   =  cs_q & ~cs_d;
    assign cs_fall   = ~cs_q &  cs_d;
    // sclk activity only counts inside a frame.
    assign sclk_rise =  sclk_q & ~sclk_d & ~cs_q;
    assign sclk_fall = ~sclk_q &  sclk_d & ~cs_q;

    // ---------------- datapath / FSM state ----------------
    resp_state_e           state;
    logic [6:0]            shift;      // command bits collected so far
    logic [2:0]            cnt;        // command bit / address nibble counter
    logic [7:0]            wait_cnt;
    logic                  half;       // 0 = next nibble is the high one
    logic [3:0]            hi_nib;
    logic                  is_read;
    logic                  set_pend, clr_pend, rst_armed;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [7:0]            wdata, rdata;

    // Command byte as it will look once the current rise is shifted in.
    logic [7:0] cmd_next;
    logic       cmd_last;
    assign cmd_next = o_qpi_mode ? {shift[3:0], sio_q} : {shift[6:0], sio_q[0]};
    assign cmd_last = o_qpi_mode ? (cnt == 3'd1) : (cnt == 3'd7);

    psram_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            o_sio      <= 4'h0;
            o_sio_oe   <= 1'b0;
            o_qpi_mode <= 1'b0;
            shift      <= 7'h0;
            cnt        <= 3'd0;
            wait_cnt   <= 8'd0;
            half       <= 1'b0;
            hi_nib     <= 4'h0;
            is_read    <= 1'b0;
            set_pend   <= 1'b0;
            clr_pend   <= 1'b0;
            rst_armed  <= 1'b0;
            addr       <= '0;
            we         <= 1'b0;
            wdata      <= 8'h0;
        end else begin
            we <= 1'b0;
            // A write commits this cycle at the old address; step past it.
            if (we) begin
                addr <= addr + 1'b1;
            end

            if (cs_rise) begin
                // End of frame: drop the bus, forget any half byte and apply a
                // mode change decoded earlier in the frame.
                state    <= ST_IDLE;
                o_sio_oe <= 1'b0;
                half     <= 1'b0;
                if (set_pend) o_qpi_mode <= 1'b1;
                if (clr_pend) o_qpi_mode <= 1'b0;
                set_pend <= 1'b0;
                clr_pend <= 1'b0;
            end else if (cs_fall) begin
                state <= ST_CMD;
                cnt   <= 3'd0;
                half  <= 1'b0;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (sclk_rise) begin
                            shift <= cmd_next[6:0];
                            if (cmd_last) begin
                                state     <= ST_IGNORE;
                                cnt       <= 3'd0;
                                rst_armed <= 1'b0;
                                case (cmd_next)
                                    CMD_ENTER_QPI: if (!o_qpi_mode) set_pend <= 1'b1;
                                    CMD_EXIT_QPI:  if (o_qpi_mode)  clr_pend <= 1'b1;
                                    CMD_RST_EN:    rst_armed <= 1'b1;
                                    CMD_RST:       if (rst_armed)   clr_pend <= 1'b1;
                                    CMD_QUAD_WRITE, CMD_QUAD_READ: begin
                                        if (o_qpi_mode) begin
                                            state   <= ST_ADDR;
                                            is_read <= (cmd_next == CMD_QUAD_READ);
                                        end
                                    end
                                    default: ;
                                endcase
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (sclk_rise) begin
                            // High address bits fall off the top of the shifter.
                            addr <= {addr[ADDR_WIDTH-5:0], sio_q};
                            if (cnt == 3'(ADDR_NIBBLES - 1)) begin
                                state    <= is_read ? ST_WAIT : ST_WR_DATA;
                                wait_cnt <= 8'd0;
                                half     <= 1'b0;
                            end else begin
                                cnt <= cnt + 3'd1;
                            end
                        end
                    end

                    ST_WAIT: begin
                        // The array read of the first byte completes during
                        // the wait, since the read port follows addr.
                        if (sclk_rise) begin
                            if (wait_cnt == WAIT_LAST) begin
                                state <= ST_RD_DATA;
                                half  <= 1'b0;
                            end else begin
                                wait_cnt <= wait_cnt + 8'd1;
                            end
                        end
                    end

                    ST_RD_DATA: begin
                        if (sclk_fall) begin
                            o_sio_oe <= 1'b1;
                            if (!half) begin
                                o_sio <= rdata[7:4];
                                half  <= 1'b1;
                            end else begin
                                // Advancing now prefetches the next byte while
                                // the low nibble is on the bus.
                                o_sio <= rdata[3:0];
                                half  <= 1'b0;
                                addr  <= addr + 1'b1;
                            end
                        end
                    end

                    ST_WR_DATA: begin
                        if (sclk_rise) begin
                            if (!half) begin
                                hi_nib <= sio_q;
                                half   <= 1'b1;
                            end else begin
                                wdata <= {hi_nib, sio_q};
                                we    <= 1'b1;
                                half  <= 1'b0;
                            end
                        end
                    end

                    default: ;  // ST_IDLE, ST_IGNORE: wait for cs edges
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// ----------------------------------------------------------------------------
// tb_psram_qpi_responder
// Drives SPI/QPI frames into the responder acting as the controller, keeps a
// byte-level memory and mode model, and checks read nibbles, output enable
// and QPI mode against it.
// ----------------------------------------------------------------------------
module tb_psram_qpi_responder;
    import psram_pkg::*;

    localparam int AW    = 12;
    localparam int RW    = 6;
    localparam int AMASK = (1 << AW) - 1;
    localparam int H     = 4;   // sclk half period in clk cycles

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_psram_cs = 1'b1;
    logic       i_psram_sclk = 1'b0;
    logic [3:0] i_sio = 4'h0;
    logic [3:0] o_sio;
    logic       o_sio_oe;
    logic       o_qpi_mode;

    always #5 clk = ~clk;

    psram_qpi_responder #(.ADDR_WIDTH(AW), .READ_WAIT(RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_psram_cs   (i_psram_cs),
        .i_psram_sclk (i_psram_sclk),
        .i_sio        (i_sio),
        .o_sio        (o_sio),
        .o_sio_oe     (o_sio_oe),
        .o_qpi_mode   (o_qpi_mode)
    );

    // ---------------- scoreboard / model state ----------------
    int         total = 0;
    int         bad = 0;
    logic [7:0] mem_m [int];        // bytes known to be in the array
    logic       model_qpi = 1'b0;   // mode the device must show now
    logic       qpi_after = 1'b0;   // mode it must show after the current frame
    logic       model_armed = 1'b0;
    logic [4:0] exp_q [$];          // {data_known, nibble} per data rise
    logic [3:0] got_q [$];          // nibbles seen on data rises
    logic [7:0] wbuf [$];
    logic       chk_on = 1'b0;
    logic       rd_window = 1'b0;
    logic       mon_rd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle: mode must track the model; oe only inside read frames.
    always @(negedge clk) begin
        if (chk_on) begin
            check("qpi_mode", 32'(o_qpi_mode), 32'(model_qpi));
            if (!rd_window) check("oe_idle", 32'(o_sio_oe), 32'd0);
        end
    end

    // Read data compare on every controller sampling rise.
    always @(posedge i_psram_sclk) begin
        logic [4:0] e;
        if (mon_rd) begin
            got_q.push_back(o_sio);
            if (exp_q.size() == 0) begin
                check("rd_extra_rise", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_oe", 32'(o_sio_oe), 32'd1);
                if (e[4]) check("rd_nibble", 32'(o_sio), 32'(e[3:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic hold();
        repeat (H) @(negedge clk);
    endtask

    task automatic sclk_cycle(input logic [3:0] nib);
        i_sio = nib;
        hold();
        i_psram_sclk = 1'b1;
        hold();
        i_psram_sclk = 1'b0;
    endtask

    task automatic qpi_byte(input logic [7:0] b);
        sclk_cycle(b[7:4]);
        sclk_cycle(b[3:0]);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, b[i]});
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) sclk_cycle(a[i*4 +: 4]);
    endtask

    task automatic frame_begin();
        i_psram_cs = 1'b0;
        hold();
    endtask

    task automatic frame_end();
        hold();
        i_psram_cs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_qpi = qpi_after;   // mode change is visible from the 2nd clk on
        @(posedge clk);
        #1;
        check("oe_off_after_cs", 32'(o_sio_oe), 32'd0);
        rd_window = 1'b0;
        hold();
    endtask

    // Single-byte command frame, framed for the current mode.
    task automatic send_cmd(input logic [7:0] b);
        frame_begin();
        if (model_qpi) qpi_byte(b); else spi_byte(b);
        if (!model_qpi && b == 8'h35) qpi_after = 1'b1;
        if (model_qpi && b == 8'hF5)  qpi_after = 1'b0;
        if (b == 8'h99 && model_armed) qpi_after = 1'b0;
        model_armed = (b == 8'h66);
        frame_end();
    endtask

    // Quad write of wbuf at a, optionally followed by a lone high nibble.
    task automatic wr(input logic [23:0] a, input bit extra, input logic [3:0] xn);
        frame_begin();
        qpi_byte(8'h38);
        send_addr(a);
        for (int i = 0; i < wbuf.size(); i++) begin
            qpi_byte(wbuf[i]);
            mem_m[(int'(a) + i) & AMASK] = wbuf[i];
        end
        if (extra) sclk_cycle(xn);
        model_armed = 1'b0;
        frame_end();
    endtask

    // Quad read at a: nwait wait rises, then nnib data rises.
    task automatic rd(input logic [23:0] a, input int nwait, input int nnib);
        int ba;
        rd_window = 1'b1;
        got_q.delete();
        frame_begin();
        qpi_byte(8'hEB);
        send_addr(a);
        for (int w = 0; w < nwait; w++) begin
            i_sio = 4'h0;
            hold();
            check("oe_wait_pre", 32'(o_sio_oe), 32'd0);
            i_psram_sclk = 1'b1;
            hold();
            check("oe_wait_post", 32'(o_sio_oe), 32'd0);
            i_psram_sclk = 1'b0;
        end
        for (int k = 0; k < nnib; k++) begin
            ba = (int'(a) + k / 2) & AMASK;
            if (mem_m.exists(ba))
                exp_q.push_back({1'b1, (k % 2 == 0) ? mem_m[ba][7:4] : mem_m[ba][3:0]});
            else
                exp_q.push_back(5'h00);
        end
        mon_rd = 1'b1;
        for (int k = 0; k < nnib; k++) begin
            hold();
            i_psram_sclk = 1'b1;
            hold();
            i_psram_sclk = 1'b0;
        end
        mon_rd = 1'b0;
        check("rd_exp_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        model_armed = 1'b0;
        frame_end();
    endtask

    function automatic logic [15:0] got4();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4 && i < got_q.size(); i++) v = {v[11:0], got_q[i]};
        return v;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #(900_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [23:0] a;
        int          n;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_oe", 32'(o_sio_oe), 32'd0);
        check("rst_qpi", 32'(o_qpi_mode), 32'd0);
        check("rst_sio", 32'(o_sio), 32'd0);
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));
        reset = 1'b1;
        chk_on = 1'b1;
        hold();

        // Enter QPI from SPI.
        send_cmd(8'h35);
        check("qpi_entered", 32'(o_qpi_mode), 32'd1);

        // Write A5 3C at 0x10 and read back.
        wbuf = '{8'hA5, 8'h3C};
        wr(24'h000010, 1'b0, 4'h0);
        rd(24'h000010, RW, 4);
        check("rd_a53c_literal", 32'(got4()), 32'h0000A53C);

        // Address wrap.
        wbuf = '{8'h11, 8'h22};
        wr(24'h000FFF, 1'b0, 4'h0);
        rd(24'h000000, RW, 2);
        check("wrap_literal", 32'(got4()), 32'h00000022);
        rd(24'h000FFF, RW, 4);
        check("wrap_span_literal", 32'(got4()), 32'h00001122);

        // Aborted write: 0x21 pre-loaded, then 1.5 bytes at 0x20.
        wbuf = '{8'h5E};
        wr(24'h000021, 1'b0, 4'h0);
        wbuf = '{8'h77};
        wr(24'h000020, 1'b1, 4'h8);
        rd(24'h000021, RW, 2);
        check("abort_21_literal", 32'(got4()), 32'h0000005E);
        rd(24'h000020, RW, 4);
        check("abort_20_literal", 32'(got4()), 32'h0000775E);

        // Reads cut short mid-wait and mid-data.
        rd(24'h000010, 3, 0);
        rd(24'h000010, RW, 3);

        // Randomized writes and reads against the model.
        for (int it = 0; it < 10; it++) begin
            a = 24'($urandom_range(0, 24'hFFFFFF));
            n = $urandom_range(1, 4);
            wbuf.delete();
            for (int i = 0; i < n; i++) wbuf.push_back(8'($urandom_range(0, 255)));
            wr(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            rd(a, RW, 2 * n);
            if (it % 3 == 0) rd(a, RW, $urandom_range(1, 2 * n));
        end

        // Exit QPI; a QPI-framed read is then garbage SPI bits and ignored.
        send_cmd(8'hF5);
        check("qpi_exited", 32'(o_qpi_mode), 32'd0);
        rd_window = 1'b0;
        frame_begin();
        qpi_byte(8'hEB);
        send_addr(24'h000010);
        for (int k = 0; k < RW + 4; k++) begin
            sclk_cycle(4'h0);
            check("oe_spi_ignored", 32'(o_sio_oe), 32'd0);
        end
        model_armed = 1'b0;
        frame_end();

        // Reset-enable then reset clear QPI mode.
        send_cmd(8'h35);
        send_cmd(8'h66);
        check("qpi_after_66", 32'(o_qpi_mode), 32'd1);
        send_cmd(8'h99);
        check("qpi_after_99", 32'(o_qpi_mode), 32'd0);

        // Async reset in the middle of a read.
        send_cmd(8'h35);
        wbuf = '{8'hA5, 8'h3C};
        wr(24'h000010, 1'b0, 4'h0);
        rd_window = 1'b1;
        got_q.delete();
        frame_begin();
        qpi_byte(8'hEB);
        send_addr(24'h000010);
        for (int w = 0; w < RW; w++) sclk_cycle(4'h0);
        exp_q.push_back({1'b1, 4'hA});
        exp_q.push_back({1'b1, 4'h5});
        mon_rd = 1'b1;
        for (int k = 0; k < 2; k++) begin
            hold();
            i_psram_sclk = 1'b1;
            hold();
            i_psram_sclk = 1'b0;
        end
        mon_rd = 1'b0;
        check("rst_rd_drained", 32'(exp_q.size()), 32'd0);
        hold();
        check("oe_before_async_rst", 32'(o_sio_oe), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_qpi = 1'b0;
        qpi_after = 1'b0;
        model_armed = 1'b0;
        #1;
        check("async_rst_oe", 32'(o_sio_oe), 32'd0);
        check("async_rst_state", 32'(dut.state), 32'(ST_IDLE));
        i_psram_cs = 1'b1;
        @(negedge clk);
        rd_window = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hold();
        send_cmd(8'h35);
        rd(24'h000010, RW, 4);
        check("post_rst_literal", 32'(got4()), 32'h0000A53C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
